// File: rtl/ias_pkg.sv
// Shared types and constants for the interrupt acknowledge sequencer.
// Optional feature macro used by the top level: IAS_SPURIOUS_DETECT_EN.
package ias_pkg;

    // Width of the pulse/gap down-counter; covers the 1..15 cycle range.
    localparam int CNT_W = 4;

    // Width of the interrupt vector read from DATABUS.
    localparam int VEC_W = 8;

    // Sequencer states, in the order they are normally visited.
    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_PULSE1 = 3'd2,
        S_GAP    = 3'd3,
        S_PULSE2 = 3'd4,
        S_HOLD   = 3'd5
    } ias_state_e;

    // Load value for the down-counter so that a phase lasts 'cycles' clocks:
    // the phase ends in the cycle where the counter reads zero.
    function automatic logic [CNT_W-1:0] cnt_load(input int cycles);
        return CNT_W'(cycles - 1);
    endfunction

endpackage : ias_pkg

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous level input.
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // Shift the raw input through two flops; both clear on reset so the
    // synchronized level starts low.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour, forming a real shift chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule : sync2

// File: rtl/interrupt_ack_sequencer.sv
// Interrupt acknowledge sequencer.
// Synchronizes INT, requests the CPU core, and after acceptance issues two
// active-low INTA pulses separated by a high gap, capturing the vector from
// DATABUS on the last cycle of the second pulse. The vector is then held
// until the core consumes it.
// Optional feature macro: IAS_SPURIOUS_DETECT_EN adds vec_spurious, which
// flags that INT had already dropped when the second pulse began.
module interrupt_ack_sequencer
    import ias_pkg::*;
#(
    parameter int INTA_LOW_CYCLES = 2,
    parameter int INTA_GAP_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             INT,
    output logic             INTA,
    input  logic [VEC_W-1:0] DATABUS,
    output logic             irq_req,
    input  logic             irq_ack,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [VEC_W-1:0] vector,
    output logic             busy
`ifdef IAS_SPURIOUS_DETECT_EN
    ,
    output logic             vec_spurious
`endif
);

    localparam logic [CNT_W-1:0] LOW_LOAD = cnt_load(INTA_LOW_CYCLES);
    localparam logic [CNT_W-1:0] GAP_LOAD = cnt_load(INTA_GAP_CYCLES);

    ias_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [VEC_W-1:0] vector_q, vector_d;
    logic             inta_q, inta_d;
    logic             int_s;

    // Bring the asynchronous interrupt line into the CLK domain.
    sync2 u_sync2 (
        .clk   (CLK),
        .rst_n (RST_N),
        .d_i   (INT),
        .q_o   (int_s)
    );

    // Next-state, counter and vector-capture logic.
    // NOTE: every signal written here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        vector_d = vector_q;

        unique case (state_q)
            S_IDLE: begin
                if (int_s) begin
                    state_d = S_REQ;
                end
            end

            S_REQ: begin
                // Acceptance wins over a withdrawn request in the same cycle.
                if (irq_ack) begin
                    state_d = S_PULSE1;
                    cnt_d   = LOW_LOAD;
                end else if (!int_s) begin
                    state_d = S_IDLE;
                end
            end

            S_PULSE1: begin
                if (cnt_q == '0) begin
                    state_d = S_GAP;
                    cnt_d   = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_GAP: begin
                if (cnt_q == '0) begin
                    state_d = S_PULSE2;
                    cnt_d   = LOW_LOAD;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_PULSE2: begin
                // The controller drives the vector during this pulse; take
                // it on the final low cycle.
                if (cnt_q == '0) begin
                    state_d  = S_HOLD;
                    vector_d = DATABUS;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_HOLD: begin
                if (vec_ready) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // INTA is decoded from the next state and registered, so the pin is a
    // flop output that goes low exactly while the FSM sits in a pulse state.
    always_comb begin
        inta_d = !((state_d == S_PULSE1) || (state_d == S_PULSE2));
    end

    // State, counter, vector and INTA registers; reset parks INTA high
    // immediately, independent of CLK.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            vector_q <= '0;
            inta_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            vector_q <= vector_d;
            inta_q   <= inta_d;
        end
    end

`ifdef IAS_SPURIOUS_DETECT_EN
    logic spurious_q;

    // Record whether the request had gone away by the first cycle of the
    // second pulse; the flag lives until the vector is consumed.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            spurious_q <= 1'b0;
        end else if ((state_q == S_PULSE2) && (cnt_q == LOW_LOAD)) begin
            spurious_q <= !int_s;
        end else if ((state_q == S_HOLD) && vec_ready) begin
            spurious_q <= 1'b0;
        end
    end

    assign vec_spurious = spurious_q;
`endif

    assign INTA      = inta_q;
    assign irq_req   = (state_q == S_REQ);
    assign vec_valid = (state_q == S_HOLD);
    assign vector    = vector_q;
    assign busy      = (state_q != S_IDLE);

endmodule : interrupt_ack_sequencer

// File: tb/tb_interrupt_ack_sequencer.sv
// Self-checking bench for interrupt_ack_sequencer.
// Instance A uses the default timing (2/2), instance B uses 1/3. Both share
// the stimulus; 'sel' chooses which instance is observed and checked.
// Expected INTA waveform, vector and flags are derived from the cycle in
// which irq_ack was accepted using plain arithmetic on the pulse widths.
module tb_interrupt_ack_sequencer;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       INT = 1'b0;
    logic [7:0] DATABUS = 8'h00;
    logic       irq_ack = 1'b0;
    logic       vec_ready = 1'b0;

    logic       a_inta, a_req, a_valid, a_busy;
    logic [7:0] a_vec;
    logic       b_inta, b_req, b_valid, b_busy;
    logic [7:0] b_vec;
`ifdef IAS_SPURIOUS_DETECT_EN
    logic       a_spur, b_spur, o_spur;
`endif

    logic       o_inta, o_req, o_valid, o_busy;
    logic [7:0] o_vec;
    bit         sel = 1'b0;

    int total = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    interrupt_ack_sequencer #(.INTA_LOW_CYCLES(2), .INTA_GAP_CYCLES(2)) u_dut_a (
        .CLK(CLK), .RST_N(RST_N), .INT(INT), .INTA(a_inta), .DATABUS(DATABUS),
        .irq_req(a_req), .irq_ack(irq_ack), .vec_valid(a_valid),
        .vec_ready(vec_ready), .vector(a_vec), .busy(a_busy)
`ifdef IAS_SPURIOUS_DETECT_EN
        , .vec_spurious(a_spur)
`endif
    );

    interrupt_ack_sequencer #(.INTA_LOW_CYCLES(1), .INTA_GAP_CYCLES(3)) u_dut_b (
        .CLK(CLK), .RST_N(RST_N), .INT(INT), .INTA(b_inta), .DATABUS(DATABUS),
        .irq_req(b_req), .irq_ack(irq_ack), .vec_valid(b_valid),
        .vec_ready(vec_ready), .vector(b_vec), .busy(b_busy)
`ifdef IAS_SPURIOUS_DETECT_EN
        , .vec_spurious(b_spur)
`endif
    );

    always_comb begin
        o_inta  = sel ? b_inta  : a_inta;
        o_req   = sel ? b_req   : a_req;
        o_valid = sel ? b_valid : a_valid;
        o_busy  = sel ? b_busy  : a_busy;
        o_vec   = sel ? b_vec   : a_vec;
`ifdef IAS_SPURIOUS_DETECT_EN
        o_spur  = sel ? b_spur  : a_spur;
`endif
    end

    function automatic int low_w();
        return sel ? 1 : 2;
    endfunction

    function automatic int gap_w();
        return sel ? 3 : 2;
    endfunction

    // Advance one clock; outputs are observed 1 time unit after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        INT = 1'b0;
        irq_ack = 1'b0;
        vec_ready = 1'b0;
        RST_N = 1'b0;
        tick();
        tick();
        total++;
        if (o_inta !== 1'b1 || o_req !== 1'b0 || o_valid !== 1'b0 ||
            o_busy !== 1'b0 || o_vec !== 8'h00) begin
            bad++;
            $display("FAIL reset_values: inta=%b req=%b valid=%b busy=%b vec=%h want 1 0 0 0 00",
                     o_inta, o_req, o_valid, o_busy, o_vec);
        end
        RST_N = 1'b1;
    endtask

    // Wait (bounded) for irq_req with random irq_ack noise while idle.
    task automatic wait_req();
        bit found = 1'b0;
        for (int n = 0; n < 8; n++) begin
            irq_ack = 1'($urandom_range(0, 1));
            tick();
            if (o_req === 1'b1) begin
                found = 1'b1;
                break;
            end
        end
        irq_ack = 1'b0;
        total++;
        if (!found) begin
            bad++;
            $display("FAIL wait_req: irq_req=%b after 8 cycles, want 1", o_req);
        end
    endtask

    // Runs a full sequence starting in a cycle where irq_req is observed high.
    // drop_at: pulse-phase cycle index at which INT is driven low (-1: keep).
    task automatic run_from_req(input int ack_delay, input int fixed_data,
                                input int drop_at, input int ready_delay);
        int         l = low_w();
        int         g = gap_w();
        int         span = 2 * l + g;
        logic [7:0] exp_vec = 8'h00;
        logic       int_at [0:40];
        logic       exp_inta;

        for (int i = 0; i < ack_delay; i++) begin
            irq_ack = 1'b0;
            vec_ready = 1'($urandom_range(0, 1));
            tick();
            total++;
            if (o_req !== 1'b1 || o_inta !== 1'b1) begin
                bad++;
                $display("FAIL req_wait: req=%b inta=%b want 1 1", o_req, o_inta);
            end
        end
        irq_ack = 1'b1;
        vec_ready = 1'($urandom_range(0, 1));
        int_at[0] = INT;
        tick();

        // Pulse phase: cycles 1..span after the accepting cycle.
        for (int k = 1; k <= span; k++) begin
            exp_inta = !((k <= l) || (k > l + g));
            total++;
            if (o_inta !== exp_inta || o_req !== 1'b0 || o_valid !== 1'b0 ||
                o_busy !== 1'b1) begin
                bad++;
                $display("FAIL pulse_cycle%0d: inta=%b req=%b valid=%b busy=%b want %b 0 0 1",
                         k, o_inta, o_req, o_valid, o_busy, exp_inta);
            end
            irq_ack = 1'($urandom_range(0, 1));
            vec_ready = 1'($urandom_range(0, 1));
            DATABUS = (fixed_data >= 0) ? 8'(fixed_data) : 8'($urandom_range(0, 255));
            if (k == span) exp_vec = DATABUS;
            if (k == drop_at) INT = 1'b0;
            int_at[k] = INT;
            tick();
        end

        // Hold phase: vector held until vec_ready.
        for (int h = 0; h <= ready_delay; h++) begin
            total++;
            if (o_valid !== 1'b1 || o_vec !== exp_vec || o_inta !== 1'b1 ||
                o_busy !== 1'b1 || o_req !== 1'b0) begin
                bad++;
                $display("FAIL hold_cycle%0d: valid=%b vec=%h inta=%b busy=%b req=%b want 1 %h 1 1 0",
                         h, o_valid, o_vec, o_inta, o_busy, o_req, exp_vec);
            end
`ifdef IAS_SPURIOUS_DETECT_EN
            total++;
            if (o_spur !== !int_at[l + g - 1]) begin
                bad++;
                $display("FAIL spurious_hold%0d: got %b want %b", h, o_spur, !int_at[l + g - 1]);
            end
`endif
            vec_ready = (h == ready_delay);
            irq_ack = 1'($urandom_range(0, 1));
            DATABUS = 8'($urandom_range(0, 255));
            tick();
        end

        // First cycle back in IDLE.
        total++;
        if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_inta !== 1'b1 ||
            o_vec !== exp_vec || o_req !== 1'b0) begin
            bad++;
            $display("FAIL exit_idle: valid=%b busy=%b inta=%b vec=%h req=%b want 0 0 1 %h 0",
                     o_valid, o_busy, o_inta, o_vec, o_req, exp_vec);
        end
`ifdef IAS_SPURIOUS_DETECT_EN
        total++;
        if (o_spur !== 1'b0) begin
            bad++;
            $display("FAIL spurious_clear: got %b want 0", o_spur);
        end
`endif
        vec_ready = 1'b0;
        irq_ack = 1'b0;
    endtask

    // Drop INT and let any pending request withdraw.
    task automatic drain();
        INT = 1'b0;
        irq_ack = 1'b0;
        vec_ready = 1'b0;
        repeat (4) tick();
        total++;
        if (o_busy !== 1'b0 || o_req !== 1'b0) begin
            bad++;
            $display("FAIL drain_idle: busy=%b req=%b want 0 0", o_busy, o_req);
        end
    endtask

    // Reset values, then exact synchronizer latency to irq_req.
    task automatic test_reset();
        sel = 1'b0;
        do_reset();
        INT = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            tick();
            total++;
            if (o_req !== (n == 3)) begin
                bad++;
                $display("FAIL sync_latency_c%0d: irq_req=%b want %b", n, o_req, (n == 3));
            end
        end
    endtask

    // Request withdrawn while in REQ: no INTA, no vector.
    task automatic test_withdraw();
        INT = 1'b0;
        for (int n = 1; n <= 6; n++) begin
            tick();
            total++;
            if (o_req !== (n <= 2) || o_inta !== 1'b1 || o_valid !== 1'b0) begin
                bad++;
                $display("FAIL withdraw_c%0d: req=%b inta=%b valid=%b want %b 1 0",
                         n, o_req, o_inta, o_valid, (n <= 2));
            end
        end
    endtask

    task automatic test_basic();
        sel = 1'b0;
        do_reset();
        INT = 1'b1;
        wait_req();
        run_from_req(0, 8'h25, span_last(), 3);
        drain();
    endtask

    // INT dropped at the first gap cycle; the sequence still completes.
    task automatic test_int_drop();
        sel = 1'b0;
        do_reset();
        INT = 1'b1;
        wait_req();
        run_from_req(1, 8'h07, low_w() + 1, 2);
        drain();
    endtask

    function automatic int span_last();
        return 2 * low_w() + gap_w();
    endfunction

    // INT held high: vec_ready in the first HOLD cycle re-requests after one IDLE cycle.
    task automatic test_rerequest();
        sel = 1'b0;
        do_reset();
        INT = 1'b1;
        wait_req();
        run_from_req(1, 8'h5A, -1, 0);
        tick();
        total++;
        if (o_req !== 1'b1) begin
            bad++;
            $display("FAIL rerequest: irq_req=%b one cycle after IDLE, want 1", o_req);
        end
        run_from_req(0, 8'hC3, -1, 2);
        drain();
    endtask

    // Reset asserted between clock edges while INTA is low.
    task automatic test_reset_mid_pulse();
        sel = 1'b0;
        do_reset();
        INT = 1'b1;
        wait_req();
        irq_ack = 1'b1;
        tick();
        irq_ack = 1'b0;
        total++;
        if (o_inta !== 1'b0) begin
            bad++;
            $display("FAIL mid_pulse_pre: inta=%b want 0", o_inta);
        end
        #1 RST_N = 1'b0;
        #1;
        total++;
        if (o_inta !== 1'b1 || o_req !== 1'b0 || o_valid !== 1'b0 ||
            o_busy !== 1'b0 || o_vec !== 8'h00) begin
            bad++;
            $display("FAIL mid_pulse_reset: inta=%b req=%b valid=%b busy=%b vec=%h want 1 0 0 0 00",
                     o_inta, o_req, o_valid, o_busy, o_vec);
        end
        INT = 1'b0;
        tick();
        RST_N = 1'b1;
        tick();
    endtask

    // Instance B: 1/3/1 widths and 10 cycles of vec_ready back-pressure.
    task automatic test_params();
        sel = 1'b1;
        do_reset();
        INT = 1'b1;
        wait_req();
        run_from_req(2, -1, 1, 10);
        drain();
        sel = 1'b0;
    endtask

    task automatic test_random();
        for (int t = 0; t < 2; t++) begin
            sel = bit'(t);
            do_reset();
            for (int i = 0; i < 12; i++) begin
                int drop;
                INT = 1'b1;
                wait_req();
                drop = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(1, span_last()));
                run_from_req(int'($urandom_range(0, 3)), -1, drop, int'($urandom_range(1, 4)));
                if (drop < 0) begin
                    drain();
                end else begin
                    INT = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                end
            end
        end
        sel = 1'b0;
    endtask

    initial begin
        #1;
        test_reset();
        test_withdraw();
        test_basic();
        test_int_drop();
        test_rerequest();
        test_reset_mid_pulse();
        test_params();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule : tb_interrupt_ack_sequencer

// File: doc/interrupt_ack_sequencer.md
INTERRUPT_ACK_SEQUENCER -- requirements
Module: interrupt_ack_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset: ports CLK and RST_N.
REQ-002 Parameter INTA_LOW_CYCLES, 2, CLK cycles each INTA low pulse lasts (legal range 1..15).
REQ-003 Parameter INTA_GAP_CYCLES, 2, CLK cycles INTA is held high between the two pulses (legal range 1..15).
REQ-004 Port CLK  in  1  rising-edge clock.
REQ-005 Port RST_N  in  1  asynchronous active-low reset.
REQ-006 Port INT  in  1  interrupt request from the interrupt controller; asynchronous, active high.
REQ-007 Port INTA  out  1  interrupt acknowledge to the controller; active low.
REQ-008 Port DATABUS  in  8  vector driven by the controller during the second INTA pulse.
REQ-009 Port irq_req  out  1  request to the CPU core.
REQ-010 Port irq_ack  in  1  CPU accepts the interrupt; sampled only while irq_req=1.
REQ-011 Port vec_valid  out  1  captured vector available.
REQ-012 Port vec_ready  in  1  CPU consumes the vector.
REQ-013 Port vector  out  8  captured vector.
REQ-014 Port busy  out  1  high in every state except IDLE.

Function
REQ-015 INT SHALL pass through a 2-flop synchronizer; int_s denotes the synchronized value.
REQ-016 The FSM SHALL have the states IDLE, REQ, PULSE1, GAP, PULSE2, HOLD.
REQ-017 IDLE: int_s=1 -> REQ on the next edge; irq_req=1 in REQ only.
REQ-018 REQ: irq_ack=1 -> PULSE1; int_s=0 with irq_ack=0 -> IDLE (request withdrawn, no INTA issued); irq_ack=1 takes priority over int_s=0.
REQ-019 PULSE1/PULSE2: INTA=0 for exactly INTA_LOW_CYCLES cycles, counted by a 4-bit down-counter loaded on state entry.
REQ-020 GAP: INTA=1 for exactly INTA_GAP_CYCLES cycles, then -> PULSE2.
REQ-021 DATABUS SHALL be registered into vector on the last cycle of PULSE2; the FSM then -> HOLD.
REQ-022 Once PULSE1 is entered, the two-pulse sequence SHALL complete regardless of INT.
REQ-023 HOLD: vec_valid=1 and vector stable; vec_ready=1 -> IDLE on the same edge, with vec_valid=0 in the next cycle.
REQ-024 INTA SHALL be driven from a flop, so it is glitch-free.
REQ-025 INT still high on return to IDLE (level-triggered re-request) SHALL start a new REQ one cycle later.
REQ-026 irq_ack and vec_ready SHALL be ignored in every state other than REQ and HOLD, respectively.

Reset
REQ-027 RST_N=0 SHALL force: state=IDLE, INTA=1, irq_req=0, vec_valid=0, vector=8'h00, busy=0, counter=0, synchronizer flops=0.
REQ-028 Reset asserted mid-sequence, including while INTA=0, SHALL drive INTA=1 immediately, without waiting for CLK.
REQ-029 After RST_N deassertion, INT SHALL need 2 synchronizer cycles plus 1 cycle before irq_req can rise.

Configuration
REQ-030 Macro IAS_SPURIOUS_DETECT_EN, when defined, SHALL add the output vec_spurious (out, 1).
- vec_spurious is set when int_s=0 on the first cycle of PULSE2.
- It is valid alongside vec_valid and is cleared on leaving HOLD.
REQ-031 Without IAS_SPURIOUS_DETECT_EN, the port and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-032 A shared package ias_pkg SHALL hold:
- the state enum type
- the counter width constant (4)
- the vector width constant (8)
REQ-033 The synchronizer SHALL be a separate sub-module, sync2, instantiated once.

Verification
REQ-034 Basic: INT=1, irq_ack=1 on irq_req, DATABUS=8'h25 during PULSE2 -> two INTA pulses of 2 cycles each, 2-cycle gap; vector=8'h25; vec_valid held until vec_ready.
REQ-035 Withdraw: INT=1 then 0 while in REQ with irq_ack=0 -> back to IDLE; INTA never asserted; vec_valid never rises.
REQ-036 INT drop mid-sequence: INT falls during GAP, DATABUS=8'h07 -> sequence completes, vector=8'h07; with IAS_SPURIOUS_DETECT_EN, vec_spurious=1.
REQ-037 Level re-request: INT held high, vec_ready=1 in the first HOLD cycle -> new irq_req one cycle after IDLE; second vector captured correctly.
REQ-038 Reset mid-pulse: RST_N=0 while INTA=0 in PULSE1 -> INTA=1 before the next CLK edge; all outputs at reset values.
REQ-039 Parameters: INTA_LOW_CYCLES=1, INTA_GAP_CYCLES=3 -> measured widths 1/3/1 cycles; back-pressure of vec_ready=0 for 10 cycles keeps vector stable.
